// File: rtl/multicycle_control_fsm_pkg.sv
// rtl/multicycle_control_fsm_pkg.sv - shared state, opcode, ALU and mux codes for the control unit
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC      = 4'd2,
    ST_WB_ALU    = 4'd3,
    ST_MEM_ADDR  = 4'd4,
    ST_MEM_READ  = 4'd5,
    ST_WB_MEM    = 4'd6,
    ST_MEM_WRITE = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9
  } state_e;

  localparam logic [2:0] OP_3R  = 3'b000;
  localparam logic [2:0] OP_2RI = 3'b001;
  localparam logic [2:0] OP_RI  = 3'b010;
  localparam logic [2:0] OP_LS  = 3'b011;
  localparam logic [2:0] OP_UJ  = 3'b100;
  localparam logic [2:0] OP_B   = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ASB_REGB  = 2'b00;
  localparam logic [1:0] ASB_TWO   = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_BRIMM = 2'b11;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] funct;
    logic       s;
    logic       ne;
    logic       legal;
  } fields_t;

endpackage

// File: rtl/multicycle_control_fsm_field_decode.sv
// rtl/multicycle_control_fsm_field_decode.sv - combinational instruction field extraction and legality
module control_field_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [15:0] instr_i,
  output fields_t     fields_o
);

  always_comb begin
    fields_o        = '0;
    fields_o.opcode = instr_i[2:0];
    fields_o.rd     = instr_i[15:13];
    fields_o.funct  = instr_i[6:3];
    fields_o.s      = instr_i[3];
    fields_o.ne     = instr_i[3];
    fields_o.legal  = !(instr_i[2] && instr_i[1]);
    case (instr_i[2:0])
      OP_3R: begin
        fields_o.rs1 = instr_i[12:10];
        fields_o.rs2 = instr_i[9:7];
      end
      OP_2RI: fields_o.rs1 = instr_i[12:10];
      // stores carry their data register in the rd slot
      OP_LS: begin
        fields_o.rs1 = instr_i[12:10];
        fields_o.rs2 = instr_i[3] ? instr_i[15:13] : 3'd0;
      end
      OP_B: begin
        fields_o.rs1 = instr_i[15:13];
        fields_o.rs2 = instr_i[12:10];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle sequencer: state register, next state, output decode, wait timer
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STATE_W     = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [15:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic [2:0]         reg_readA_address,
  output logic [2:0]         reg_readB_address,
  output logic               reg_write,
  output logic [2:0]         reg_write_address,
  output logic               memToReg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_op,
  output logic [2:0]         imm_sel,
  output logic               illegal,
  output logic               bus_error,
  output logic [STATE_W-1:0] state_dbg
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             waiting;
  fields_t          f;

  control_field_decode u_decode (
    .instr_i  (instr),
    .fields_o (f)
  );

  assign state_dbg = STATE_W'(Reset ? ST_FETCH : state_q);

  always_comb begin
    state_d           = state_q;
    waiting           = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = PC_SRC_ALU;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    iord              = 1'b0;
    reg_readA_address = '0;
    reg_readB_address = '0;
    reg_write         = 1'b0;
    reg_write_address = '0;
    memToReg          = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = ASB_REGB;
    alu_op            = ALU_ADD;
    imm_sel           = '0;
    illegal           = 1'b0;
    bus_error         = 1'b0;
    // outputs are forced quiet while Reset is high so a pending access is abandoned immediately
    if (!Reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = ASB_TWO;
            state_d   = ST_DECODE;
          end else begin
            waiting = 1'b1;
          end
        end
        ST_DECODE: begin
          reg_readA_address = f.rs1;
          reg_readB_address = f.rs2;
          alu_src_b         = ASB_BRIMM;
          imm_sel           = f.opcode;
          if (!f.legal) begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end else begin
            case (f.opcode)
              OP_LS:   state_d = ST_MEM_ADDR;
              OP_UJ:   state_d = ST_JUMP;
              OP_B:    state_d = ST_BRANCH;
              default: state_d = ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = (f.opcode == OP_3R) ? ASB_REGB : ASB_IMM;
          alu_op    = (f.opcode == OP_2RI) ? ALU_ADD : f.funct;
          imm_sel   = f.opcode;
          state_d   = ST_WB_ALU;
        end
        ST_WB_ALU: begin
          reg_write         = 1'b1;
          reg_write_address = f.rd;
          state_d           = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          imm_sel   = f.opcode;
          state_d   = f.s ? ST_MEM_WRITE : ST_MEM_READ;
        end
        ST_MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_d = ST_WB_MEM;
          else           waiting = 1'b1;
        end
        ST_WB_MEM: begin
          reg_write         = 1'b1;
          memToReg          = 1'b1;
          reg_write_address = f.rd;
          state_d           = ST_FETCH;
        end
        ST_MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) state_d = ST_FETCH;
          else           waiting = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = PC_SRC_ALUOUT;
          pc_write  = zero ^ f.ne;
          state_d   = ST_FETCH;
        end
        ST_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          state_d  = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
      if (waiting && (MEM_TIMEOUT != 0) && (wait_q == CNT_LAST)) begin
        bus_error = 1'b1;
        waiting   = 1'b0;
        state_d   = ST_FETCH;
      end
    end
    // any cycle that is not a continued wait clears the counter, so every wait state starts at zero
    wait_d = !waiting ? '0 : (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_write, pc_write, mem_read, mem_write, iord, reg_write, memToReg, alu_src_a;
  logic        illegal, bus_error;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  reg_readA_address, reg_readB_address, reg_write_address, imm_sel;
  logic [3:0]  alu_op, state_dbg;
  logic [33:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .STATE_W(4)) dut (
    .CLK(CLK), .Reset(Reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .reg_readA_address(reg_readA_address),
    .reg_readB_address(reg_readB_address), .reg_write(reg_write),
    .reg_write_address(reg_write_address), .memToReg(memToReg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .illegal(illegal),
    .bus_error(bus_error), .state_dbg(state_dbg)
  );

  assign obs = {ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_readA_address,
                reg_readB_address, reg_write, reg_write_address, memToReg, alu_src_a,
                alu_src_b, alu_op, imm_sel, illegal, bus_error, state_dbg};

  // Expected control word for one cycle of a given phase, straight from the per-state rules
  function automatic logic [33:0] exp_vec(input state_e ph, input logic [15:0] in,
                                          input logic z, input logic rdy, input logic to);
    logic irw = 0, pcw = 0, mr = 0, mw = 0, io = 0, rw = 0, m2r = 0, asa = 0, ill = 0, be = 0;
    logic [1:0] pcs = 0, asb = 0;
    logic [2:0] ra = 0, rb = 0, wa = 0, isel = 0;
    logic [3:0] aop = 0;
    logic [2:0] op = in[2:0];
    case (ph)
      ST_FETCH: begin
        mr = 1; be = to;
        if (rdy) begin irw = 1; pcw = 1; asb = 2'b01; end
      end
      ST_DECODE: begin
        asb = 2'b11; isel = op; ill = (op > 3'd5);
        if (op == 3'd0) begin ra = in[12:10]; rb = in[9:7]; end
        if (op == 3'd1) ra = in[12:10];
        if (op == 3'd3) begin ra = in[12:10]; rb = in[3] ? in[15:13] : 3'd0; end
        if (op == 3'd5) begin ra = in[15:13]; rb = in[12:10]; end
      end
      ST_EXEC: begin
        asa = 1; isel = op; asb = (op == 3'd0) ? 2'b00 : 2'b10;
        aop = (op == 3'd1) ? ALU_ADD : in[6:3];
      end
      ST_WB_ALU:    begin rw = 1; wa = in[15:13]; end
      ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; aop = ALU_ADD; isel = op; end
      ST_MEM_READ:  begin mr = 1; io = 1; be = to; end
      ST_WB_MEM:    begin rw = 1; m2r = 1; wa = in[15:13]; end
      ST_MEM_WRITE: begin mw = 1; io = 1; be = to; end
      ST_BRANCH:    begin asa = 1; aop = ALU_SUB; pcs = 2'b01; pcw = z ^ in[3]; end
      ST_JUMP:      begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {irw, pcw, pcs, mr, mw, io, ra, rb, rw, wa, m2r, asa, asb, aop, isel, ill, be, 4'(ph)};
  endfunction

  // Cycle count from the latency table plus memory stalls, or the point where a timeout cuts it short
  function automatic int exp_cycles(input logic [15:0] in, input int fw, input int mw);
    logic [2:0] op = in[2:0];
    if (fw >= TO) return TO;
    if (op <= 3'd2) return 4 + fw;
    if (op == 3'd3) begin
      if (mw >= TO) return fw + 3 + TO;
      return (in[3] ? 4 : 5) + fw + mw;
    end
    if (op <= 3'd5) return 3 + fw;
    return 2 + fw;
  endfunction

  // Drives one instruction from FETCH back to FETCH, checking every cycle's control word
  task automatic run_instr(input logic [15:0] in, input int fw, input int mw, input logic z,
                           input string tag, output int cycles);
    state_e seq[$];
    logic [33:0] e;
    logic to, waitable;
    logic [2:0] op = in[2:0];
    cycles = 0;
    instr = in;
    zero = z;
    seq = {ST_FETCH, ST_DECODE};
    case (op)
      3'd0, 3'd1, 3'd2: seq = {seq, ST_EXEC, ST_WB_ALU};
      3'd3: seq = in[3] ? {seq, ST_MEM_ADDR, ST_MEM_WRITE} : {seq, ST_MEM_ADDR, ST_MEM_READ, ST_WB_MEM};
      3'd4: seq = {seq, ST_JUMP};
      3'd5: seq = {seq, ST_BRANCH};
      default: ;
    endcase
    foreach (seq[i]) begin
      waitable = (seq[i] == ST_FETCH) || (seq[i] == ST_MEM_READ) || (seq[i] == ST_MEM_WRITE);
      for (int k = 0; k < 64; k++) begin
        mem_ready = waitable ? (k == ((seq[i] == ST_FETCH) ? fw : mw)) : 1'($urandom);
        to = waitable && !mem_ready && (k == TO - 1);
        #2;
        e = exp_vec(seq[i], in, z, mem_ready, to);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL %s instr=%h phase=%0d k=%0d: got %h expected %h", tag, in, seq[i], k, obs, e);
        end
        @(posedge CLK); #1;
        cycles++;
        if (to) return;
        if (!waitable || mem_ready) break;
      end
    end
  endtask

  task automatic test_reset;
    state_e ph_l[4] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ};
    Reset = 1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      #2; n_checks++;
      if (obs !== 34'h0) begin n_fail++; $display("FAIL reset_hold got %h expected 0", obs); end
      @(posedge CLK); #1;
    end
    Reset = 0;
    instr = 16'h8833;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      #2; n_checks++;
      if (obs !== exp_vec(ph_l[i], instr, 0, mem_ready, 0)) begin
        n_fail++; $display("FAIL reset_lead phase=%0d got %h expected %h", i, obs, exp_vec(ph_l[i], instr, 0, mem_ready, 0));
      end
      @(posedge CLK); #1;
    end
    Reset = 1;
    for (int i = 0; i < 3; i++) begin
      #2; n_checks++;
      if (obs !== 34'h0) begin n_fail++; $display("FAIL reset_mid got %h expected 0", obs); end
      @(posedge CLK); #1;
    end
    Reset = 0;
    #2; n_checks++;
    if (obs !== exp_vec(ST_FETCH, instr, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset_release got %h expected %h", obs, exp_vec(ST_FETCH, instr, 0, 0, 0));
    end
    Reset = 1;
    @(posedge CLK); #1;
    Reset = 0;
  endtask

  task automatic test_directed;
    logic [15:0] ins[9] = '{16'h4080, 16'h8833, 16'h883B, 16'h0405, 16'h0405, 16'h040D, 16'h1234, 16'h0007, 16'h0006};
    int fws[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int mws[9] = '{0, 3, 0, 0, 0, 0, 0, 0, 0};
    logic zs[9] = '{0, 0, 0, 1, 0, 1, 0, 0, 0};
    int cyc;
    for (int i = 0; i < 9; i++) begin
      run_instr(ins[i], fws[i], mws[i], zs[i], "directed", cyc);
      n_checks++;
      if (cyc !== exp_cycles(ins[i], fws[i], mws[i])) begin
        n_fail++; $display("FAIL directed_latency instr=%h got %0d expected %0d", ins[i], cyc, exp_cycles(ins[i], fws[i], mws[i]));
      end
    end
  endtask

  task automatic test_timeout;
    logic [15:0] ins[4] = '{16'h4080, 16'h4080, 16'h8833, 16'h883B};
    int fws[4] = '{99, 3, 0, 1};
    int mws[4] = '{0, 0, 99, 99};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      run_instr(ins[i], fws[i], mws[i], 0, "timeout", cyc);
      n_checks++;
      if (cyc !== exp_cycles(ins[i], fws[i], mws[i])) begin
        n_fail++; $display("FAIL timeout_latency instr=%h got %0d expected %0d", ins[i], cyc, exp_cycles(ins[i], fws[i], mws[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] in;
    int fw, mw, cyc;
    for (int i = 0; i < 120; i++) begin
      in = 16'($urandom);
      fw = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
      mw = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 5);
      run_instr(in, fw, mw, 1'($urandom), "random", cyc);
      n_checks++;
      if (cyc !== exp_cycles(in, fw, mw)) begin
        n_fail++; $display("FAIL random_latency instr=%h fw=%0d mw=%0d got %0d expected %0d", in, fw, mw, cyc, exp_cycles(in, fw, mw));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
